// File: rtl/vote_logger_pkg.sv
// Shared definitions for the vote logger: FSM state encodings, mode values
// and the read-select width used by the interface and the top.
package vote_logger_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ARMED  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

    localparam int RD_SEL_W = 4;

endpackage

// File: rtl/vote_logger_if.sv
// Ballot/vote/readout signal bundle between the control side (master) and
// the vote logger (slave).
interface vote_logger_if #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
) ();

    logic                                 mode;
    logic                                 ballot_en;
    logic                                 clear;
    logic [N_CAND-1:0]                    valid_vote_in;
    logic                                 rd_req;
    logic [vote_logger_pkg::RD_SEL_W-1:0] rd_sel;
    logic                                 ballot_ready;
    logic                                 vote_ack;
    logic                                 vote_err;
    logic                                 rd_valid;
    logic [CNT_W-1:0]                     rd_data;
    logic                                 rd_err;
    logic [CNT_W-1:0]                     total_votes;

    modport master (
        output mode, ballot_en, clear, valid_vote_in, rd_req, rd_sel,
        input  ballot_ready, vote_ack, vote_err, rd_valid, rd_data, rd_err, total_votes
    );

    modport slave (
        input  mode, ballot_en, clear, valid_vote_in, rd_req, rd_sel,
        output ballot_ready, vote_ack, vote_err, rd_valid, rd_data, rd_err, total_votes
    );

endinterface

// File: rtl/vote_logger_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX_VAL)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/vote_logger.sv
// Ballot-gated vote tally: accepts one one-hot vote per issued ballot into
// per-candidate saturating counters and serves the tallies in result mode.
module vote_logger
    import vote_logger_pkg::*;
#(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
) (
    input  logic           clock,
    input  logic           reset,
    vote_logger_if.slave   bus
);

    localparam logic [N_CAND-1:0]   ONE_VOTE  = N_CAND'(1);
    localparam logic [RD_SEL_W:0]   SEL_LIMIT = (RD_SEL_W + 1)'(N_CAND);

    state_t              r_state;
    logic                r_ballot_ready;
    logic                r_vote_ack;
    logic                r_vote_err;
    logic                r_rd_valid;
    logic                r_rd_err;
    logic [CNT_W-1:0]    r_rd_data;

    logic [N_CAND-1:0]   w_vote;
    logic                w_any;
    logic                w_single;
    logic                w_multi;
    logic                w_count;
    logic                w_clr;
    logic [N_CAND-1:0]   w_inc;
    logic [CNT_W-1:0]    w_tally [N_CAND];
    logic [CNT_W-1:0]    w_total;
    logic [CNT_W-1:0]    w_rd_mux;
    logic                w_rd_oob;

    // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
    assign w_vote   = bus.valid_vote_in;
    assign w_any    = |w_vote;
    assign w_single = w_any && ((w_vote & (w_vote - ONE_VOTE)) == '0);
    assign w_multi  = w_any && !w_single;

    assign w_count = (r_state == ST_ARMED) && (bus.mode == MODE_VOTE) && w_single;
    assign w_clr   = (r_state == ST_IDLE) && (bus.mode == MODE_VOTE) && bus.clear;
    assign w_inc   = w_count ? w_vote : '0;

    for (genvar g = 0; g < N_CAND; g++) begin : g_tally
        sat_counter #(.CNT_W(CNT_W)) u_tally (
            .clock (clock),
            .reset (reset),
            .clr   (w_clr),
            .inc   (w_inc[g]),
            .q     (w_tally[g])
        );
    end

    sat_counter #(.CNT_W(CNT_W)) u_total (
        .clock (clock),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_count),
        .q     (w_total)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (bus.rd_sel == RD_SEL_W'(i)) begin
                w_rd_mux = w_tally[i];
            end
        end
    end

    assign w_rd_oob = {1'b0, bus.rd_sel} >= SEL_LIMIT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_INIT;
            r_ballot_ready <= 1'b0;
            r_vote_ack     <= 1'b0;
            r_vote_err     <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_err       <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_vote_ack <= 1'b0;
            r_vote_err <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            case (r_state)
                // Debouncers still assert valid_vote here, so nothing is sampled.
                ST_INIT: begin
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.mode == MODE_RESULT) begin
                        r_state <= ST_RESULT;
                    end else if (!bus.clear && bus.ballot_en) begin
                        r_state        <= ST_ARMED;
                        r_ballot_ready <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bus.mode == MODE_RESULT) begin
                        r_state        <= ST_RESULT;
                        r_ballot_ready <= 1'b0;
                    end else if (w_single) begin
                        r_state        <= ST_IDLE;
                        r_ballot_ready <= 1'b0;
                        r_vote_ack     <= 1'b1;
                    end else if (w_multi) begin
                        r_vote_err <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (bus.rd_req) begin
                        r_rd_valid <= 1'b1;
                        r_rd_err   <= w_rd_oob;
                        r_rd_data  <= w_rd_oob ? '0 : w_rd_mux;
                    end
                    if (bus.mode == MODE_VOTE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.ballot_ready = r_ballot_ready;
    assign bus.vote_ack     = r_vote_ack;
    assign bus.vote_err     = r_vote_err;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_err       = r_rd_err;
    assign bus.rd_data      = r_rd_data;
    assign bus.total_votes  = w_total;

endmodule
